rst_sequencer: RTL and testbench

- Downstream consumer of the design's synchronized global reset.
- Holds every subsystem in reset, then releases the per-subsystem resets one stage at a time.
- Waits for each subsystem's ready acknowledge before releasing the next stage.
- Flags subsystems that never acknowledge, and supports a software-requested full re-sequence. Sits between the reset synchronizer and the top-level subsystems.

---
 rtl/rst_seq_pkg.sv | 23 ++
 rtl/rst_sequencer_if.sv | 34 +++
 rtl/rst_sequencer_rdy_sync.sv | 26 ++
 rtl/rst_sequencer.sv | 107 ++++++++++
 tb/tb_rst_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and defaults for the reset sequencer.
// State encoding plus parameter defaults and a small helper.
package rst_seq_pkg;

   typedef enum logic [1:0] {
      ST_ASSERT,
      ST_WAIT,
      ST_DONE,
      ST_ERR
   } state_t;

   localparam int DEF_NUM_STAGES     = 4;
   localparam int DEF_HOLD_CYCLES    = 16;
   localparam int DEF_TIMEOUT_CYCLES = 1024;

   function automatic int max_int(
      input int a,
      input int b
   );
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/rst_sequencer_if.sv
// Control/status bundle between the sequencer and its users.
// slave = sequencer side, master = driver of requests/acks.
interface rst_sequencer_if #(
   parameter int NUM_STAGES = 4
) ();

   localparam int IW = $clog2(NUM_STAGES);

   logic                  sw_rst_req;
   logic [NUM_STAGES-1:0] stage_rdy;
   logic [NUM_STAGES-1:0] stage_rst_n;
   logic                  all_rdy;
   logic                  timeout_err;
   logic [IW-1:0]         stage_idx;

   modport master (
      output sw_rst_req,
      output stage_rdy,
      input  stage_rst_n,
      input  all_rdy,
      input  timeout_err,
      input  stage_idx
   );

   modport slave (
      input  sw_rst_req,
      input  stage_rdy,
      output stage_rst_n,
      output all_rdy,
      output timeout_err,
      output stage_idx
   );

endinterface

// File: rtl/rst_sequencer_rdy_sync.sv
// Two-flop synchronizer for one ready acknowledge bit.
// Used only when RST_SEQ_SYNC_RDY_EN is defined.
module rdy_sync (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   // Shift the async input through two flops.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/rst_sequencer.sv
// Staged reset release with per-stage ready handshake.
// Optional macro RST_SEQ_SYNC_RDY_EN: synchronize stage_rdy.
module rst_sequencer
   import rst_seq_pkg::*;
#(
   parameter int NUM_STAGES     = DEF_NUM_STAGES,
   parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic RST_n,
   rst_sequencer_if.slave bus
);

   localparam int IW = $clog2(NUM_STAGES);
   localparam int CW =
      $clog2(max_int(HOLD_CYCLES, TIMEOUT_CYCLES)) + 1;

   localparam logic [CW-1:0] HOLD_LAST =
      CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] TO_LAST =
      CW'(TIMEOUT_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST =
      IW'(NUM_STAGES - 1);

   state_t                r_state;
   logic [CW-1:0]         r_cnt;
   logic [NUM_STAGES-1:0] r_rst_n;
   logic                  r_all_rdy;
   logic                  r_err;
   logic [IW-1:0]         r_idx;

   logic [NUM_STAGES-1:0] w_rdy;
   logic [IW-1:0]         w_nxt_idx;

`ifdef RST_SEQ_SYNC_RDY_EN
   for (genvar g = 0; g < NUM_STAGES; g++) begin : g_sync
      rdy_sync u_sync (
         .i_clk   (clk),
         .i_rst_n (RST_n),
         .i_d     (bus.stage_rdy[g]),
         .o_q     (w_rdy[g])
      );
   end
`else
   assign w_rdy = bus.stage_rdy;
`endif

   assign w_nxt_idx = r_idx + IW'(1);

   // Sequencer FSM; every output is a register.
   always_ff @(posedge clk or negedge RST_n) begin
      if (!RST_n) begin
         r_state   <= ST_ASSERT;
         r_cnt     <= '0;
         r_rst_n   <= '0;
         r_all_rdy <= 1'b0;
         r_err     <= 1'b0;
         r_idx     <= '0;
      end else if (bus.sw_rst_req) begin
         r_state   <= ST_ASSERT;
         r_cnt     <= '0;
         r_rst_n   <= '0;
         r_all_rdy <= 1'b0;
         r_err     <= 1'b0;
         r_idx     <= '0;
      end else begin
         unique case (r_state)
            ST_ASSERT: begin
               if (r_cnt == HOLD_LAST) begin
                  r_rst_n[0] <= 1'b1;
                  r_cnt      <= '0;
                  r_state    <= ST_WAIT;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            ST_WAIT: begin
               if (w_rdy[r_idx]) begin
                  if (r_idx == IDX_LAST) begin
                     r_state   <= ST_DONE;
                     r_all_rdy <= 1'b1;
                  end else begin
                     r_idx              <= w_nxt_idx;
                     r_rst_n[w_nxt_idx] <= 1'b1;
                     r_cnt              <= '0;
                  end
               end else if (r_cnt == TO_LAST) begin
                  r_state <= ST_ERR;
                  r_err   <= 1'b1;
                  r_rst_n <= '0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            ST_DONE: ;
            ST_ERR:  ;
         endcase
      end
   end

   assign bus.stage_rst_n = r_rst_n;
   assign bus.all_rdy     = r_all_rdy;
   assign bus.timeout_err = r_err;
   assign bus.stage_idx   = r_idx;

endmodule

// File: tb/tb_rst_sequencer.sv
// Scoreboard bench for rst_sequencer at default parameters.
// Observed word = {stage_rst_n, all_rdy, timeout_err, stage_idx}.
module tb_rst_sequencer;

   logic clk;
   logic RST_n;

   rst_sequencer_if #(.NUM_STAGES(4)) bus ();

   rst_sequencer u_dut (
      .clk   (clk),
      .RST_n (RST_n),
      .bus   (bus)
   );

`ifdef RST_SEQ_SYNC_RDY_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   int vectors = 0;
   int miscompares = 0;
   logic [7:0] exp_q[$];
   logic [7:0] ev;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] obs();
      return {bus.stage_rst_n, bus.all_rdy,
              bus.timeout_err, bus.stage_idx};
   endfunction

   // Expected word e edges after a restart, all stages ready.
   function automatic logic [7:0] seq_exp(int e);
      int n;
      int i;
      logic [3:0] r;
      n = (e < 16) ? 0 : ((e - 15 > 4) ? 4 : e - 15);
      i = (e < 16) ? 0 : ((e - 16 > 3) ? 3 : e - 16);
      r = 4'((1 << n) - 1);
      return {r, (e >= 20), 1'b0, 2'(i)};
   endfunction

   // Expected word with stage 2 never acknowledging.
   function automatic logic [7:0] to_exp(int e);
      if (e < 16)   return 8'h00;
      if (e == 16)  return 8'b0001_0000;
      if (e == 17)  return 8'b0011_0001;
      if (e < 1042) return 8'b0111_0010;
      return 8'b0000_0110;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_sw();
      bus.sw_rst_req = 1'b1;
      tick();
      bus.sw_rst_req = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      exp_q.push_back(8'h00);
      ev = exp_q.pop_front();
      vectors++;
      if (obs() !== ev) begin
         miscompares++;
         $display("FAIL reset got %h exp %h", obs(), ev);
      end
      for (int k = 0; k < 2; k++) begin
         exp_q.push_back(8'h00);
         tick();
         ev = exp_q.pop_front();
         vectors++;
         if (obs() !== ev) begin
            miscompares++;
            $display("FAIL reset_hold got %h exp %h", obs(), ev);
         end
      end
   endtask

   task automatic test_sequence();
      bus.stage_rdy = 4'hF;
      RST_n = 1'b1;
      for (int e = 1; e <= 24; e++) begin
         exp_q.push_back(seq_exp(e));
         tick();
         ev = exp_q.pop_front();
         vectors++;
         if (obs() !== ev) begin
            miscompares++;
            $display("FAIL seq e=%0d got %h exp %h", e, obs(), ev);
         end
      end
      bus.stage_rdy = 4'h0;
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back(8'b1111_1011);
         tick();
         ev = exp_q.pop_front();
         vectors++;
         if (obs() !== ev) begin
            miscompares++;
            $display("FAIL done_hold got %h exp %h", obs(), ev);
         end
      end
   endtask

   task automatic test_sw_from_done();
      bus.stage_rdy = 4'hF;
      exp_q.push_back(8'h00);
      pulse_sw();
      ev = exp_q.pop_front();
      vectors++;
      if (obs() !== ev) begin
         miscompares++;
         $display("FAIL sw_done got %h exp %h", obs(), ev);
      end
      for (int e = 1; e <= 22; e++) begin
         exp_q.push_back(seq_exp(e));
         tick();
         ev = exp_q.pop_front();
         vectors++;
         if (obs() !== ev) begin
            miscompares++;
            $display("FAIL sw_done_seq e=%0d got %h exp %h",
                     e, obs(), ev);
         end
      end
   endtask

   task automatic test_timeout();
      bus.stage_rdy = 4'b1011;
      exp_q.push_back(8'h00);
      pulse_sw();
      ev = exp_q.pop_front();
      vectors++;
      if (obs() !== ev) begin
         miscompares++;
         $display("FAIL to_start got %h exp %h", obs(), ev);
      end
      for (int e = 1; e <= 1100; e++) begin
         exp_q.push_back(to_exp(e));
         tick();
         ev = exp_q.pop_front();
         vectors++;
         if (obs() !== ev) begin
            miscompares++;
            $display("FAIL timeout e=%0d got %h exp %h",
                     e, obs(), ev);
         end
      end
   endtask

   task automatic test_sw_from_err();
      bus.stage_rdy = 4'hF;
      exp_q.push_back(8'h00);
      pulse_sw();
      ev = exp_q.pop_front();
      vectors++;
      if (obs() !== ev) begin
         miscompares++;
         $display("FAIL sw_err got %h exp %h", obs(), ev);
      end
      for (int e = 1; e <= 22; e++) begin
         exp_q.push_back(seq_exp(e));
         tick();
         ev = exp_q.pop_front();
         vectors++;
         if (obs() !== ev) begin
            miscompares++;
            $display("FAIL sw_err_seq e=%0d got %h exp %h",
                     e, obs(), ev);
         end
      end
   endtask

   task automatic test_async_reset();
      bus.stage_rdy = 4'b1101;
      exp_q.push_back(8'h00);
      pulse_sw();
      ev = exp_q.pop_front();
      vectors++;
      if (obs() !== ev) begin
         miscompares++;
         $display("FAIL ar_start got %h exp %h", obs(), ev);
      end
      for (int e = 1; e <= 20; e++) begin
         exp_q.push_back((e < 16) ? 8'h00 :
                         (e == 16) ? 8'b0001_0000 :
                                     8'b0011_0001);
         tick();
         ev = exp_q.pop_front();
         vectors++;
         if (obs() !== ev) begin
            miscompares++;
            $display("FAIL ar_pre e=%0d got %h exp %h",
                     e, obs(), ev);
         end
      end
      #2;
      RST_n = 1'b0;
      exp_q.push_back(8'h00);
      #1;
      ev = exp_q.pop_front();
      vectors++;
      if (obs() !== ev) begin
         miscompares++;
         $display("FAIL ar_async got %h exp %h", obs(), ev);
      end
      tick();
      tick();
      bus.stage_rdy = 4'hF;
      RST_n = 1'b1;
      for (int e = 1; e <= 22; e++) begin
         exp_q.push_back(seq_exp(e));
         tick();
         ev = exp_q.pop_front();
         vectors++;
         if (obs() !== ev) begin
            miscompares++;
            $display("FAIL ar_post e=%0d got %h exp %h",
                     e, obs(), ev);
         end
      end
   endtask

   task automatic test_sw_vs_ready();
      bus.stage_rdy = 4'b0111;
      exp_q.push_back(8'h00);
      pulse_sw();
      ev = exp_q.pop_front();
      vectors++;
      if (obs() !== ev) begin
         miscompares++;
         $display("FAIL svr_start got %h exp %h", obs(), ev);
      end
      for (int e = 1; e <= 22; e++) begin
         exp_q.push_back((e < 16)  ? 8'h00 :
                         (e == 16) ? 8'b0001_0000 :
                         (e == 17) ? 8'b0011_0001 :
                         (e == 18) ? 8'b0111_0010 :
                                     8'b1111_0011);
         tick();
         ev = exp_q.pop_front();
         vectors++;
         if (obs() !== ev) begin
            miscompares++;
            $display("FAIL svr_pre e=%0d got %h exp %h",
                     e, obs(), ev);
         end
      end
      bus.stage_rdy = 4'hF;
      exp_q.push_back(8'h00);
      pulse_sw();
      ev = exp_q.pop_front();
      vectors++;
      if (obs() !== ev) begin
         miscompares++;
         $display("FAIL svr_race got %h exp %h", obs(), ev);
      end
      for (int e = 1; e <= 22; e++) begin
         exp_q.push_back(seq_exp(e));
         tick();
         ev = exp_q.pop_front();
         vectors++;
         if (obs() !== ev) begin
            miscompares++;
            $display("FAIL svr_post e=%0d got %h exp %h",
                     e, obs(), ev);
         end
      end
   endtask

   task automatic test_rdy_latency();
      bus.stage_rdy = 4'h0;
      exp_q.push_back(8'h00);
      pulse_sw();
      ev = exp_q.pop_front();
      vectors++;
      if (obs() !== ev) begin
         miscompares++;
         $display("FAIL lat_start got %h exp %h", obs(), ev);
      end
      for (int e = 1; e <= 18; e++) begin
         exp_q.push_back((e < 16) ? 8'h00 : 8'b0001_0000);
         tick();
         ev = exp_q.pop_front();
         vectors++;
         if (obs() !== ev) begin
            miscompares++;
            $display("FAIL lat_pre e=%0d got %h exp %h",
                     e, obs(), ev);
         end
      end
      bus.stage_rdy = 4'b0001;
      for (int k = 1; k <= LAT + 1; k++) begin
         exp_q.push_back((k < LAT) ? 8'b0001_0000 :
                                     8'b0011_0001);
         tick();
         ev = exp_q.pop_front();
         vectors++;
         if (obs() !== ev) begin
            miscompares++;
            $display("FAIL latency k=%0d got %h exp %h",
                     k, obs(), ev);
         end
      end
   endtask

   initial begin
      RST_n          = 1'b0;
      bus.sw_rst_req = 1'b0;
      bus.stage_rdy  = 4'h0;
      test_reset();
      test_sequence();
      test_sw_from_done();
      test_timeout();
      test_sw_from_err();
      test_async_reset();
      test_sw_vs_ready();
      test_rdy_latency();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
